serial_pattern_tx: RTL

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

---
 rtl/serial_pattern_tx.sv | 99 +++++++++
 1 files changed

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: captures an 8-bit pattern and shifts bits len..0 out
// MSB-first on a registered serial line, repeating the frame repeat_cnt+1
// times back-to-back, then pulses done for one cycle.
//
// Handshake: a transmission is accepted on a rising edge where load=1 and
// ready=1 (IDLE). ready stays high until that edge and drops the cycle the
// first bit appears; load at any other time is dropped, never queued.
module serial_pattern_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] pattern,
  input  logic [2:0] len,
  input  logic [3:0] repeat_cnt,
  input  logic       abort,
  output logic       data,
  output logic       ready,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0] state;
  logic [7:0] pat_q;
  logic [2:0] len_q;
  logic [2:0] bit_idx;    // index of the bit currently on data
  logic [3:0] frame_cnt;  // frames still to send after the current one

  logic [2:0] next_idx;

  // Index of the following bit within the current frame.
  always_comb begin
    next_idx = bit_idx - 3'd1;
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    ready = (state == IDLE);
    busy  = (state == SHIFT);
    done  = (state == DONE);
  end

  // Main FSM: capture on accept, shift bits, reload between frames, finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data      <= 1'b0;
      pat_q     <= 8'd0;
      len_q     <= 3'd0;
      bit_idx   <= 3'd0;
      frame_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          // load wins over abort here: abort only cancels a running frame.
          if (load) begin
            pat_q     <= pattern;
            len_q     <= len;
            bit_idx   <= len;
            frame_cnt <= repeat_cnt;
            data      <= pattern[len];
            state     <= SHIFT;
          end else begin
            data <= 1'b0;
          end
        end
        SHIFT: begin
          if (abort) begin
            data  <= 1'b0;
            state <= IDLE;
          end else if (bit_idx != 3'd0) begin
            bit_idx <= next_idx;
            data    <= pat_q[next_idx];
          end else if (frame_cnt != 4'd0) begin
            // Next frame starts immediately, no idle gap.
            frame_cnt <= frame_cnt - 4'd1;
            bit_idx   <= len_q;
            data      <= pat_q[len_q];
          end else begin
            data  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          data  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          data  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
